// File: rtl/wm_phase_monitor_if.sv
// Observation bundle between the washer controller and its phase monitor.
// Controller-side phase/start/clear signals flow in; monitor status flows out.
// The controller (or a bench standing in for it) uses the master modport.
interface wm_phase_monitor_if #(
   parameter int CYC_W = 8
);
   // Observed controller outputs plus the operator fault-clear request
   logic             start;
   logic             wash;
   logic             rinse;
   logic             spin;
   logic             clear_fault;

   // Monitor status, all registered inside the monitor
   logic             phase_done;
   logic             cycle_done;
   logic             fault;
   logic [2:0]       fault_code;
   logic [CYC_W-1:0] cycle_count;

   modport master (
      output start, wash, rinse, spin, clear_fault,
      input  phase_done, cycle_done, fault, fault_code, cycle_count
   );

   modport slave (
      input  start, wash, rinse, spin, clear_fault,
      output phase_done, cycle_done, fault, fault_code, cycle_count
   );
endinterface

// File: rtl/wm_phase_monitor.sv
// Washer phase monitor: checks phase order, one-hot phases and per-phase durations, counts cycles, latches first fault.
// Latency: every output is registered and reflects the inputs sampled on the preceding rising edge (1 cycle).
// Backpressure: none; a passive observer that never stalls the controller, it only flags violations.
module wm_phase_monitor #(
   parameter int CNT_W     = 8,
   parameter int CYC_W     = 8,
   parameter int ARM_TO    = 4,
   parameter int WASH_MIN  = 2,
   parameter int WASH_MAX  = 4,
   parameter int RINSE_MIN = 2,
   parameter int RINSE_MAX = 4,
   parameter int SPIN_MIN  = 2,
   parameter int SPIN_MAX  = 4
) (
   input  logic              clk,
   input  logic              reset,
   wm_phase_monitor_if.slave mon
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_WASH,
      ST_RINSE,
      ST_SPIN,
      ST_FAULT
   } state_t;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_ONEHOT  = 3'd1;
   localparam logic [2:0] FC_ORDER   = 3'd2;
   localparam logic [2:0] FC_SHORT   = 3'd3;
   localparam logic [2:0] FC_LONG    = 3'd4;
   localparam logic [2:0] FC_NOSTART = 3'd5;

   // Limits resized once to the counter width so comparisons stay width-exact
   localparam logic [CNT_W-1:0] ARM_TO_C    = CNT_W'(ARM_TO);
   localparam logic [CNT_W-1:0] WASH_MIN_C  = CNT_W'(WASH_MIN);
   localparam logic [CNT_W-1:0] WASH_MAX_C  = CNT_W'(WASH_MAX);
   localparam logic [CNT_W-1:0] RINSE_MIN_C = CNT_W'(RINSE_MIN);
   localparam logic [CNT_W-1:0] RINSE_MAX_C = CNT_W'(RINSE_MAX);
   localparam logic [CNT_W-1:0] SPIN_MIN_C  = CNT_W'(SPIN_MIN);
   localparam logic [CNT_W-1:0] SPIN_MAX_C  = CNT_W'(SPIN_MAX);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dur_q, dur_d;
   logic [CNT_W-1:0] arm_q, arm_d;
   logic             phase_done_q, phase_done_d;
   logic             cycle_done_q, cycle_done_d;
   logic             fault_q, fault_d;
   logic [2:0]       fault_code_q, fault_code_d;
   logic [CYC_W-1:0] cycle_count_q, cycle_count_d;

   logic             any_hi;
   logic             multi_hi;
   logic [2:0]       err;

   // Phase-line summaries shared by every state
   assign any_hi   = mon.wash | mon.rinse | mon.spin;
   assign multi_hi = (mon.wash & mon.rinse) | (mon.wash & mon.spin) | (mon.rinse & mon.spin);

   // State register and registered outputs; reset returns to IDLE with every output low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         dur_q         <= '0;
         arm_q         <= '0;
         phase_done_q  <= 1'b0;
         cycle_done_q  <= 1'b0;
         fault_q       <= 1'b0;
         fault_code_q  <= FC_NONE;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         dur_q         <= dur_d;
         arm_q         <= arm_d;
         phase_done_q  <= phase_done_d;
         cycle_done_q  <= cycle_done_d;
         fault_q       <= fault_d;
         fault_code_q  <= fault_code_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   // Next-state logic: legal progress first, then a fault (highest-priority code) overrides everything
   always_comb begin
      state_d       = state_q;
      dur_d         = dur_q;
      arm_d         = arm_q;
      phase_done_d  = 1'b0;
      cycle_done_d  = 1'b0;
      fault_d       = fault_q;
      fault_code_d  = fault_code_q;
      cycle_count_d = cycle_count_q;
      err           = FC_NONE;

      case (state_q)
         ST_IDLE: begin
            if (any_hi) begin
               // Only a wash accompanied by start may skip the armed wait
               if (mon.start && mon.wash && !mon.rinse && !mon.spin) begin
                  state_d = ST_WASH;
                  dur_d   = CNT_W'(1);
               end else begin
                  err = FC_ORDER;
               end
            end else if (mon.start) begin
               state_d = ST_ARMED;
               arm_d   = '0;
            end
         end

         ST_ARMED: begin
            if (mon.rinse || mon.spin) begin
               err = FC_ORDER;
            end else if (mon.wash) begin
               state_d = ST_WASH;
               dur_d   = CNT_W'(1);
            end else if (arm_q + 1'b1 >= ARM_TO_C) begin
               err = FC_NOSTART;
            end else begin
               arm_d = arm_q + 1'b1;
            end
         end

         ST_WASH: begin
            if (mon.wash) begin
               // Sample that would take dur past the limit is itself the violation
               if (dur_q >= WASH_MAX_C) err = FC_LONG;
               else                     dur_d = dur_q + 1'b1;
            end else if (mon.rinse && !mon.spin) begin
               if (dur_q < WASH_MIN_C) begin
                  err = FC_SHORT;
               end else begin
                  state_d      = ST_RINSE;
                  dur_d        = CNT_W'(1);
                  phase_done_d = 1'b1;
               end
            end else begin
               err = FC_ORDER;
            end
         end

         ST_RINSE: begin
            if (mon.rinse) begin
               if (dur_q >= RINSE_MAX_C) err = FC_LONG;
               else                      dur_d = dur_q + 1'b1;
            end else if (mon.spin && !mon.wash) begin
               if (dur_q < RINSE_MIN_C) begin
                  err = FC_SHORT;
               end else begin
                  state_d      = ST_SPIN;
                  dur_d        = CNT_W'(1);
                  phase_done_d = 1'b1;
               end
            end else begin
               err = FC_ORDER;
            end
         end

         ST_SPIN: begin
            if (mon.spin) begin
               if (dur_q >= SPIN_MAX_C) err = FC_LONG;
               else                     dur_d = dur_q + 1'b1;
            end else if (!mon.wash && !mon.rinse) begin
               if (dur_q < SPIN_MIN_C) begin
                  err = FC_SHORT;
               end else begin
                  // Cycle complete: count saturates rather than wrapping
                  state_d      = ST_IDLE;
                  dur_d        = '0;
                  phase_done_d = 1'b1;
                  cycle_done_d = 1'b1;
                  if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
               end
            end else begin
               err = FC_ORDER;
            end
         end

         ST_FAULT: begin
            // Clearing is only safe once the controller has dropped every phase
            if (mon.clear_fault && !any_hi) begin
               state_d      = ST_IDLE;
               dur_d        = '0;
               arm_d        = '0;
               fault_d      = 1'b0;
               fault_code_d = FC_NONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            dur_d   = '0;
            arm_d   = '0;
         end
      endcase

      // Overlapping phases outrank every state-specific violation
      if ((state_q != ST_FAULT) && multi_hi) err = FC_ONEHOT;

      if (err != FC_NONE) begin
         state_d       = ST_FAULT;
         fault_d       = 1'b1;
         fault_code_d  = err;
         phase_done_d  = 1'b0;
         cycle_done_d  = 1'b0;
         dur_d         = dur_q;
         arm_d         = arm_q;
         cycle_count_d = cycle_count_q;
      end
   end

   assign mon.phase_done  = phase_done_q;
   assign mon.cycle_done  = cycle_done_q;
   assign mon.fault       = fault_q;
   assign mon.fault_code  = fault_code_q;
   assign mon.cycle_count = cycle_count_q;

endmodule
